// File: rtl/frame_config_pkg.sv
// rtl/frame_config_pkg.sv - shared constants, header field positions and FSM state type
package frame_config_pkg;

    localparam logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1;
    localparam logic [7:0]  DESYNC_COL    = 8'hFF;
    localparam int          HDR_FIELD_W   = 8;
    localparam int          HDR_COL_LSB   = 24;
    localparam int          HDR_FRAME_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

endpackage

// File: rtl/frame_data_shifter.sv
// rtl/frame_data_shifter.sv - row-indexed frame register with top-row-first word counter
module frame_data_shifter #(
    parameter int NUMBER_OF_ROWS = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         load_i,
    input  logic                         clear_i,
    input  logic [31:0]                  word_i,
    output logic                         last_word_o,
    output logic [32*NUMBER_OF_ROWS-1:0] frame_data_o
);
    import frame_config_pkg::*;

    localparam int CNT_W = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_OF_ROWS - 1);

    logic [NUMBER_OF_ROWS-1:0][31:0] rows_q, rows_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                row_idx;

    assign row_idx      = LAST_CNT - cnt_q;
    assign last_word_o  = load_i && (cnt_q == LAST_CNT);
    assign frame_data_o = rows_q;

    always_comb begin
        rows_d = rows_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            rows_d[row_idx] = word_i;
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rows_q <= '0;
            cnt_q  <= '0;
        end else begin
            rows_q <= rows_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_config_fsm.sv
// rtl/frame_config_fsm.sv - config word stream to fabric frame writes; FRAME_ERR_CNT_EN adds a dropped-frame counter
module frame_config_fsm
    import frame_config_pkg::*;
#(
    parameter int NUMBER_OF_ROWS     = 16,
    parameter int NUMBER_OF_COLS     = 16,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [31:0]                   write_data_i,
    input  logic                          word_write_strobe_i,
    output logic [32*NUMBER_OF_ROWS-1:0]  frame_data_o,
    output logic [NUMBER_OF_COLS-1:0]     frame_select_o,
    output logic [MAX_FRAMES_PER_COL-1:0] frame_strobe_o,
    output logic                          config_active_o,
`ifdef FRAME_ERR_CNT_EN
    output logic [7:0]                    frame_err_cnt_o,
`endif
    output logic                          frame_err_o
);

    state_t                        state_q, state_d;
    logic [HDR_FIELD_W-1:0]        col_q, col_d;
    logic [HDR_FIELD_W-1:0]        frame_q, frame_d;
    logic                          drop_q, drop_d;
    logic                          active_q, active_d;
    logic                          err_q, err_d;
    logic [NUMBER_OF_COLS-1:0]     sel_q, sel_d;
    logic [MAX_FRAMES_PER_COL-1:0] strb_q, strb_d;
    logic                          load, clear, last_word;
    logic [HDR_FIELD_W-1:0]        hdr_col, hdr_frame;
    logic                          hdr_in_range;
`ifdef FRAME_ERR_CNT_EN
    logic [7:0]                    err_cnt_q, err_cnt_d;
    assign frame_err_cnt_o = err_cnt_q;
`endif

    assign hdr_col         = write_data_i[HDR_COL_LSB +: HDR_FIELD_W];
    assign hdr_frame       = write_data_i[HDR_FRAME_LSB +: HDR_FIELD_W];
    assign hdr_in_range    = (int'(hdr_col) < NUMBER_OF_COLS) && (int'(hdr_frame) < MAX_FRAMES_PER_COL);
    assign frame_select_o  = sel_q;
    assign frame_strobe_o  = strb_q;
    assign config_active_o = active_q;
    assign frame_err_o     = err_q;

    frame_data_shifter #(
        .NUMBER_OF_ROWS(NUMBER_OF_ROWS)
    ) u_shifter (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      (load),
        .clear_i     (clear),
        .word_i      (write_data_i),
        .last_word_o (last_word),
        .frame_data_o(frame_data_o)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        frame_d  = frame_q;
        drop_d   = drop_q;
        active_d = active_q;
        err_d    = err_q;
        sel_d    = '0;
        strb_d   = '0;
        load     = 1'b0;
        clear    = 1'b0;
`ifdef FRAME_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (word_write_strobe_i && write_data_i == SYNC_WORD) begin
                    state_d  = HEADER;
                    active_d = 1'b1;
                    err_d    = 1'b0;
                end
            end
            HEADER: begin
                if (word_write_strobe_i) begin
                    if (hdr_col == DESYNC_COL) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else if (write_data_i != SYNC_WORD) begin
                        col_d   = hdr_col;
                        frame_d = hdr_frame;
                        drop_d  = !hdr_in_range;
                        clear   = 1'b1;
                        state_d = DATA;
                        if (!hdr_in_range) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (word_write_strobe_i) begin
                    load = 1'b1;
                    if (last_word) begin
                        state_d = HEADER;
                        // Dropped frames still consume every row word, but never strobe.
                        if (!drop_q) begin
                            for (int c = 0; c < NUMBER_OF_COLS; c++) begin
                                sel_d[c] = (col_q == HDR_FIELD_W'(c));
                            end
                            for (int f = 0; f < MAX_FRAMES_PER_COL; f++) begin
                                strb_d[f] = (frame_q == HDR_FIELD_W'(f));
                            end
                        end
`ifdef FRAME_ERR_CNT_EN
                        else if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            col_q    <= '0;
            frame_q  <= '0;
            drop_q   <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            strb_q   <= '0;
`ifdef FRAME_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            active_q <= active_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            strb_q   <= strb_d;
`ifdef FRAME_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_frame_config_fsm.sv
// tb/tb_frame_config_fsm.sv - scoreboard bench for frame_config_fsm
module tb_frame_config_fsm;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  wdata = '0;
    logic         wstb = 1'b0;
    logic [511:0] frame_data;
    logic [15:0]  frame_select;
    logic [19:0]  frame_strobe;
    logic         config_active;
    logic         frame_err;
`ifdef FRAME_ERR_CNT_EN
    logic [7:0]   frame_err_cnt;
`endif

    typedef struct {
        logic [15:0]  sel;
        logic [19:0]  strb;
        logic [511:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc    = 0;

    always #5 clk = ~clk;

    frame_config_fsm dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .write_data_i       (wdata),
        .word_write_strobe_i(wstb),
        .frame_data_o       (frame_data),
        .frame_select_o     (frame_select),
        .frame_strobe_o     (frame_strobe),
        .config_active_o    (config_active),
`ifdef FRAME_ERR_CNT_EN
        .frame_err_cnt_o    (frame_err_cnt),
`endif
        .frame_err_o        (frame_err)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (sb.size() > 0 && sb[0].cyc < ncyc) begin
            e = sb.pop_front();
            chk("strobe_missing", 512'(frame_strobe), 512'(e.strb));
        end
        if (frame_strobe != '0 || frame_select != '0) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", {frame_select, frame_strobe}, 512'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", 512'(ncyc), 512'(e.cyc));
                chk("frame_select", 512'(frame_select), 512'(e.sel));
                chk("frame_strobe", 512'(frame_strobe), 512'(e.strb));
                chk("frame_data", frame_data, e.data);
            end
        end
    end

    task automatic send(input logic [31:0] w);
        wdata = w;
        wstb  = 1'b1;
        @(posedge clk);
        #1;
        wstb  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] col, input logic [7:0] frm, input logic [31:0] base);
        exp_t         e;
        logic [511:0] d;
        d = '0;
        send({col, frm, 16'h0000});
        for (int i = 0; i < 16; i++) begin
            d[(15-i)*32 +: 32] = base + 32'(i);
            send(base + 32'(i));
        end
        if (col < 8'd16 && frm < 8'd20) begin
            e.sel  = 16'd1 << col;
            e.strb = 20'd1 << frm;
            e.data = d;
            e.cyc  = ncyc + 1;
            sb.push_back(e);
        end
    endtask

    initial begin
        #2;
        chk("rst_data", frame_data, 512'd0);
        chk("rst_select", 512'(frame_select), 512'd0);
        chk("rst_strobe", 512'(frame_strobe), 512'd0);
        chk("rst_active", 512'(config_active), 512'd0);
        chk("rst_err", 512'(frame_err), 512'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        send(32'h0203_0000);
        for (int i = 0; i < 5; i++) send(32'h7700_0000 + 32'(i));
        repeat (2) @(posedge clk);
        #1;
        chk("presync_data", frame_data, 512'd0);
        chk("presync_active", 512'(config_active), 512'd0);

        send(32'hFAB0_FAB1);
        chk("sync_active", 512'(config_active), 512'd1);
        send(32'hFAB0_FAB1);
        send_frame(8'd2, 8'd3, 32'h1000_0000);
        repeat (2) @(posedge clk);
        #1;
        chk("row15", 512'(frame_data[15*32 +: 32]), 512'h1000_0000);
        chk("row0", 512'(frame_data[31:0]), 512'h1000_000F);

        send_frame(8'd5, 8'd7, 32'h2000_0000);
        send_frame(8'd15, 8'd19, 32'h3000_0000);

        chk("err_before", 512'(frame_err), 512'd0);
        send_frame(8'h15, 8'd0, 32'h4000_0000);
        chk("err_after_col", 512'(frame_err), 512'd1);
`ifdef FRAME_ERR_CNT_EN
        chk("err_cnt_1", 512'(frame_err_cnt), 512'd1);
`endif
        send_frame(8'd0, 8'd0, 32'h5000_0000);
        send_frame(8'd1, 8'd20, 32'h5100_0000);
`ifdef FRAME_ERR_CNT_EN
        chk("err_cnt_2", 512'(frame_err_cnt), 512'd2);
`endif

        send(32'hFF00_0000);
        chk("desync_active", 512'(config_active), 512'd0);
        send(32'h0102_0000);
        for (int i = 0; i < 16; i++) send(32'h8800_0000 + 32'(i));
        repeat (2) @(posedge clk);
        #1;
        chk("desync_err_held", 512'(frame_err), 512'd1);
        send(32'hFAB0_FAB1);
        chk("resync_err_clr", 512'(frame_err), 512'd0);
        chk("resync_active", 512'(config_active), 512'd1);

        send(32'h0406_0000);
        for (int i = 0; i < 7; i++) send(32'h9900_0000 + 32'(i));
        reset_n = 1'b0;
        #1;
        chk("midrst_data", frame_data, 512'd0);
        chk("midrst_active", 512'(config_active), 512'd0);
        chk("midrst_err", 512'(frame_err), 512'd0);
`ifdef FRAME_ERR_CNT_EN
        chk("midrst_err_cnt", 512'(frame_err_cnt), 512'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(32'hFAB0_FAB1);
        send_frame(8'd4, 8'd6, 32'h6000_0000);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 512'(sb.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
